rr_grant_encoder: RTL and testbench
===================================

Name: rr_grant_encoder

Overview:
- Four-requester round-robin arbiter that produces a registered 2-bit grant index plus a valid flag.
- Sits directly upstream of the 2-to-4 encoder stage. gnt_idx drives the encoder's 2-bit select input, and the encoder's 4-bit one-hot output gates the granted resource.
- Holds a grant until the owner releases it, then rotates priority so no requester starves.

Parameters:
- REQ_N, 4, number of requesters; fixed at 4 to match the 2-bit encoder select.
- IDX_W, 2, grant index width; must equal clog2(REQ_N).
- MAX_HOLD, 15, grant-timeout limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- req  input  4  request vector; bit i = requester i wants the resource; level-sensitive.
- done  input  1  single-cycle release pulse from the current owner.
- gnt_idx  output  2  index of the granted requester; feeds the encoder select.
- gnt_vld  output  1  high while gnt_idx names a valid owner.
- busy  output  1  high in GRANT and RELEASE states.

Behaviour:
- Reset (rst_n low at a clk edge):
  - gnt_idx=0, gnt_vld=0, busy=0.
  - Priority pointer ptr=0, state=IDLE.
  - Reset mid-grant drops gnt_vld on that same edge with no RELEASE cycle.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ... with wrap-around mod 4.
  - On the next edge: gnt_idx<=winner, gnt_vld<=1, state<=GRANT.
  - If req == 0, stay in IDLE with outputs unchanged (gnt_vld=0; gnt_idx keeps its last value).
- Latency: req asserted before edge N gives gnt_vld=1 after edge N (1 cycle).
- GRANT:
  - gnt_idx is stable; changes from other req bits are ignored.
  - Release condition: done=1, OR req[gnt_idx]==0 (owner abandoned).
  - On release: gnt_vld<=0, ptr<=(gnt_idx+1) mod 4 with 2-bit natural wrap (3 -> 0), state<=RELEASE.
- RELEASE:
  - Mandatory one-cycle dead time; gnt_vld=0 so the downstream one-hot output deasserts before the next grant.
  - Next state is always IDLE.
  - Back-to-back grant minimum period: 1 (grant) + 1 (release) + 1 (arbitrate) cycles.
- done outside GRANT is ignored.
- done and a new req in the same cycle: the release is taken and the new req is arbitrated from IDLE.
- All four requesting continuously: grants rotate 0,1,2,3,0...
- Single requester re-requesting: it is granted again after the dead time, since the pointer wraps past the other, empty slots.
- busy = (state != IDLE).

Optional Feature:
- Macro: RR_GRANT_TIMEOUT_EN.
- With the macro:
  - A 4-bit hold counter clears on grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD with no release, a forced release is taken (same transition as done).
  - An extra output timeout (1 bit) pulses high for exactly that release cycle.
- Without the macro: no counter and no timeout port; a grant is held indefinitely until done or the owner's request drops.

Decomposition:
- Shared package rr_grant_pkg holds:
  - The state typedef (IDLE/GRANT/RELEASE, 2-bit encoding 00/01/10).
  - REQ_N and IDX_W constants.
  - The MAX_HOLD default.
- One natural sub-module: rr_pick. It is purely combinational: it takes req[3:0] and ptr[1:0] and returns winner[1:0] and any_req, by rotate-priority-unrotate.
- The top level holds the FSM, pointer and optional counter.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=4'b1111 -> gnt_vld=0, gnt_idx=0, busy=0. First grant after release of reset goes to idx 0.
- Single request: req=4'b0100 -> gnt_idx=2, gnt_vld=1 one cycle later. After a done pulse -> gnt_vld=0 for exactly one cycle, and ptr becomes 3.
- Rotation: req=4'b1111 held, done pulsed each grant -> gnt_idx sequence 0,1,2,3,0, with one dead cycle between each grant.
- Wrap: ptr=3 and req=4'b0011 -> grant idx 0, not 1.
- Abandon and reset: owner idx 1 drops req[1] mid-grant -> release with no done. A separate run asserts rst_n=0 mid-GRANT -> gnt_vld=0 on that edge and state returns to IDLE.
- RR_GRANT_TIMEOUT_EN with MAX_HOLD=15 and no done -> forced release after 15 GRANT cycles, timeout pulses once, and the next requester is granted.

Source files
------------

// File: rtl/rr_grant_pkg.sv
// Shared types and constants for the round-robin grant encoder.
package rr_grant_pkg;

  localparam int unsigned REQ_N    = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned MAX_HOLD = 15;
  localparam int unsigned HOLD_W   = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StGrant   = 2'b01,
    StRelease = 2'b10
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
module rr_pick
  import rr_grant_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [2*REQ_N-1:0] req_dbl;
  logic [REQ_N-1:0]   req_rot;
  logic [IDX_W-1:0]   offset;

  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: REQ_N];
    offset  = '0;
    // Descending scan so the lowest set bit of the rotated vector wins.
    for (int i = REQ_N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = IDX_W'(i);
      end
    end
    winner  = ptr + offset;
    any_req = |req;
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// Four-requester round-robin arbiter with registered grant index and release dead time.
// Optional grant timeout is compiled in with RR_GRANT_TIMEOUT_EN (adds the timeout port).
module rr_grant_encoder
  import rr_grant_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_N-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             busy
`ifdef RR_GRANT_TIMEOUT_EN
  ,output logic            timeout
`endif
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             owner_release;

  rr_pick u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign owner_release = done || !req[idx_q];

`ifdef RR_GRANT_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;
  logic              hold_hit;

  // Hit on the last permitted GRANT cycle so exactly MAX_HOLD cycles are held.
  assign hold_hit = (hold_q == HOLD_W'(MAX_HOLD - 1));
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
`ifdef RR_GRANT_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          idx_d   = winner;
          vld_d   = 1'b1;
          state_d = StGrant;
`ifdef RR_GRANT_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      StGrant: begin
`ifdef RR_GRANT_TIMEOUT_EN
        if (owner_release || hold_hit) begin
          timeout_d = !owner_release;
`else
        if (owner_release) begin
`endif
          vld_d   = 1'b0;
          ptr_d   = idx_q + 1'b1;
          state_d = StRelease;
        end
`ifdef RR_GRANT_TIMEOUT_EN
        else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

`ifdef RR_GRANT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Bench for rr_grant_encoder: owner/cooldown model checked every cycle plus directed literals.
module tb_rr_grant_encoder;

  localparam int MaxHold = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       busy;
`ifdef RR_GRANT_TIMEOUT_EN
  logic       timeout;
`endif

  rr_grant_encoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .busy    (busy)
`ifdef RR_GRANT_TIMEOUT_EN
    ,.timeout (timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Model: who owns the resource (-1 = nobody), whether a cooldown cycle is pending,
  // where the next search starts, and how many grant cycles the owner has had.
  int m_owner = -1;
  int m_cool  = 0;
  int m_next  = 0;
  int m_idx   = 0;
  int m_held  = 0;
  int m_to    = 0;

  always @(posedge clk) begin
    m_to = 0;
    if (!rst_n) begin
      m_owner = -1; m_cool = 0; m_next = 0; m_idx = 0; m_held = 0;
    end else if (m_owner >= 0) begin
      if (done || !req[m_owner]) begin
        m_next = (m_owner + 1) % 4; m_owner = -1; m_cool = 1;
      end
`ifdef RR_GRANT_TIMEOUT_EN
      else if (m_held == MaxHold) begin
        m_next = (m_owner + 1) % 4; m_owner = -1; m_cool = 1; m_to = 1;
      end
`endif
      else begin
        m_held++;
      end
    end else if (m_cool != 0) begin
      m_cool = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_next + k) % 4]) begin
          m_owner = (m_next + k) % 4;
          m_idx   = m_owner;
          m_held  = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_vld", int'(gnt_vld), int'(m_owner >= 0));
      chk("model_idx", int'(gnt_idx), m_idx);
      chk("model_busy", int'(busy), int'(m_owner >= 0 || m_cool != 0));
`ifdef RR_GRANT_TIMEOUT_EN
      chk("model_timeout", int'(timeout), m_to);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int vld, input int idx, input int bsy);
    chk({name, "_vld"}, int'(gnt_vld), vld);
    chk({name, "_idx"}, int'(gnt_idx), idx);
    chk({name, "_busy"}, int'(busy), bsy);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    expect_out("reset", 0, 0, 0);

    // Full rotation with a done pulse on each grant.
    rst_n = 1'b1;
    tick();
    expect_out("first_grant", 1, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      done = 1'b1;
      tick();
      expect_out("rot_release", 0, (k + 3) % 4, 1);
      done = 1'b0;
      tick();
      tick();
      expect_out("rot_grant", 1, k % 4, 1);
    end
    done = 1'b1;
    tick();

    // Single request from a pointer of 1.
    done = 1'b0;
    req  = 4'b0100;
    tick();
    tick();
    expect_out("single_grant", 1, 2, 1);
    done = 1'b1;
    tick();
    expect_out("single_release", 0, 2, 1);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    expect_out("single_idle", 0, 2, 0);

    // Pointer is 3: req 0011 must wrap to 0.
    req = 4'b0011;
    tick();
    expect_out("wrap_grant", 1, 0, 1);
    req = 4'b0010;
    tick();
    expect_out("abandon0_release", 0, 0, 1);
    tick();
    tick();
    expect_out("grant1", 1, 1, 1);
    req = 4'b1111;
    tick();
    expect_out("ignore_other_req", 1, 1, 1);
    req = 4'b1101;
    tick();
    expect_out("abandon1_release", 0, 1, 1);

    // Reset in the middle of a grant.
    req = 4'b1000;
    tick();
    tick();
    expect_out("grant3", 1, 3, 1);
    rst_n = 1'b0;
    tick();
    expect_out("reset_mid_grant", 0, 0, 0);
    rst_n = 1'b1;
    req   = 4'b0010;
    tick();
    expect_out("post_reset_grant", 1, 1, 1);

    // Done with a new request, and done while idle.
    req  = 4'b0110;
    done = 1'b1;
    tick();
    req  = 4'b0000;
    tick();
    tick();
    expect_out("done_idle_ignored", 0, 1, 0);
    done = 1'b0;
    req  = 4'b0110;
    tick();
    expect_out("next_after_done", 1, 2, 1);

    for (int i = 0; i < 80; i++) begin
      if (i % 3 == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 4) == 0);
      tick();
    end
    done = 1'b0;

`ifdef RR_GRANT_TIMEOUT_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 4'b0011;
    tick();
    expect_out("to_grant", 1, 0, 1);
    for (int i = 0; i < MaxHold - 1; i++) tick();
    chk("to_still_held", int'(gnt_vld), 1);
    chk("to_not_yet", int'(timeout), 0);
    tick();
    chk("to_pulse", int'(timeout), 1);
    expect_out("to_release", 0, 0, 1);
    tick();
    chk("to_pulse_end", int'(timeout), 0);
    tick();
    expect_out("to_next_grant", 1, 1, 1);
`endif

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
